btn_repeat_db: RTL and testbench

Upstream input-conditioning stage for pushbutton-driven counters and menus on the display board. It synchronizes and debounces one raw switch and outputs a clean level plus single-cycle press and release ticks. While the button is held it also generates auto-repeat ticks. Downstream counters consume the ticks directly, so they need no edge detectors of their own.

---
 rtl/btn_repeat_db_if.sv | 35 +++
 rtl/btn_repeat_db.sv | 209 ++++++++++++++++++++
 tb/tb_btn_repeat_db.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_repeat_db_if.sv
// Pushbutton conditioner bus: raw switch and repeat enable in,
// debounced level and single-cycle event ticks out.
interface btn_repeat_db_if;

   logic sw;
   logic rpt_en;
   logic db;
   logic press_tick;
   logic release_tick;
   logic repeat_tick;
   logic long;

   // The side that owns the button and consumes the ticks.
   modport master (
      output sw,
      output rpt_en,
      input  db,
      input  press_tick,
      input  release_tick,
      input  repeat_tick,
      input  long
   );

   // The conditioner itself.
   modport slave (
      input  sw,
      input  rpt_en,
      output db,
      output press_tick,
      output release_tick,
      output repeat_tick,
      output long
   );

endinterface

// File: rtl/btn_repeat_db.sv
// Synchronizes and debounces one raw pushbutton, producing a clean level,
// press/release ticks, a long-hold flag and auto-repeat ticks while held.
module btn_repeat_db #(
   parameter int TICK_W       = 19,
   parameter int DB_TICKS     = 2,
   parameter int HOLD_TICKS   = 50,
   parameter int REPEAT_TICKS = 10
) (
   input  logic           clk,
   input  logic           reset,
   btn_repeat_db_if.slave bus
);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   localparam logic [3:0] DbLoad  = 4'(DB_TICKS);
   localparam logic [7:0] HoldLim = 8'(HOLD_TICKS);
   localparam logic [7:0] RptLim  = 8'(REPEAT_TICKS);

   logic              sync1_q;
   logic              sync2_q;
   logic              sSw;

   logic [TICK_W-1:0] presc_q;
   logic              mTick;

   state_t            state_q;
   state_t            state_d;
   logic [3:0]        cnt_q;
   logic [3:0]        cnt_d;
   logic [7:0]        hcnt_q;
   logic [7:0]        hcnt_d;
   logic              rptPhase_q;
   logic              rptPhase_d;

   logic [7:0]        hcntInc;
   logic              holdHit;
   logic              repeatHit;

   logic              db_q;
   logic              db_d;
   logic              press_q;
   logic              press_d;
   logic              release_q;
   logic              release_d;
   logic              repeat_q;
   logic              repeat_d;
   logic              long_q;
   logic              long_d;

   // Two-flop synchronizer; only its second stage is used internally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.sw;
         sync2_q <= sync1_q;
      end
   end

   assign sSw = sync2_q;

   // Free-running prescaler; a sample tick is the single cycle it reads zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + TICK_W'(1);
      end
   end

   assign mTick = (presc_q == '0);

   // Hold counter saturates so a very long hold never wraps into a false repeat.
   assign hcntInc   = (hcnt_q == 8'hFF) ? hcnt_q : hcnt_q + 8'd1;
   assign holdHit   = !rptPhase_q && (hcntInc == HoldLim);
   assign repeatHit =  rptPhase_q && (hcntInc == RptLim);

   // State register together with every registered output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ZERO;
         cnt_q      <= '0;
         hcnt_q     <= '0;
         rptPhase_q <= 1'b0;
         db_q       <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         repeat_q   <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hcnt_q     <= hcnt_d;
         rptPhase_q <= rptPhase_d;
         db_q       <= db_d;
         press_q    <= press_d;
         release_q  <= release_d;
         repeat_q   <= repeat_d;
         long_q     <= long_d;
      end
   end

   // Next-state logic: debounce counting, hold timing and bounce recovery.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hcnt_d     = hcnt_q;
      rptPhase_d = rptPhase_q;
      unique case (state_q)
         ZERO: begin
            if (sSw) begin
               state_d = WAIT1;
               cnt_d   = DbLoad;
            end
         end
         WAIT1: begin
            if (!sSw) begin
               state_d = ZERO;
            end else if (mTick) begin
               if (cnt_q == 4'd1) begin
                  state_d    = ONE;
                  hcnt_d     = '0;
                  rptPhase_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         ONE: begin
            if (!sSw) begin
               state_d = WAIT0;
               cnt_d   = DbLoad;
            end else if (mTick) begin
               if (holdHit) begin
                  hcnt_d     = '0;
                  rptPhase_d = 1'b1;
               end else if (repeatHit) begin
                  hcnt_d = '0;
               end else begin
                  hcnt_d = hcntInc;
               end
            end
         end
         WAIT0: begin
            // A bounce back to high resumes the hold where it left off.
            if (sSw) begin
               state_d = ONE;
            end else if (mTick) begin
               if (cnt_q == 4'd1) begin
                  state_d = ZERO;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = ZERO;
         end
      endcase
   end

   // Output logic: next values of the level, long flag and one-cycle ticks.
   always_comb begin
      db_d      = db_q;
      long_d    = long_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         WAIT1: begin
            if (sSw && mTick && (cnt_q == 4'd1)) begin
               db_d    = 1'b1;
               press_d = 1'b1;
            end
         end
         ONE: begin
            if (sSw && mTick && (holdHit || repeatHit)) begin
               repeat_d = bus.rpt_en;
               if (holdHit) begin
                  long_d = 1'b1;
               end
            end
         end
         WAIT0: begin
            if (!sSw && mTick && (cnt_q == 4'd1)) begin
               db_d      = 1'b0;
               release_d = 1'b1;
               long_d    = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.db           = db_q;
   assign bus.press_tick   = press_q;
   assign bus.release_tick = release_q;
   assign bus.repeat_tick  = repeat_q;
   assign bus.long         = long_q;

endmodule

// File: tb/tb_btn_repeat_db.sv
// Self-checking bench for btn_repeat_db: directed scenarios plus random
// switch activity, compared every cycle against a level/pending-count model.
module tb_btn_repeat_db;

   localparam int TickW       = 4;
   localparam int DbTicks     = 2;
   localparam int HoldTicks   = 4;
   localparam int RepeatTicks = 2;
   localparam int TickPeriod  = 1 << TickW;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   btn_repeat_db_if bus ();

   btn_repeat_db #(
      .TICK_W      (TickW),
      .DB_TICKS    (DbTicks),
      .HOLD_TICKS  (HoldTicks),
      .REPEAT_TICKS(RepeatTicks)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the debounced level plus how many sample ticks remain
   // before it flips (0 = settled), and hold time since the last event.
   bit mSyncA, mSyncB, mS, mTickNow;
   int mEdges;
   bit mLevel;
   int mPend;
   int mHeld;
   bit mRepeating;
   bit mLong;
   bit mPress, mRelease, mRepeat;

   // Event bookkeeping from observed outputs.
   int tbCycle = 0;
   int pressCnt, releaseCnt, repeatCnt;
   int lastPressCycle, longRiseCycle;
   bit prevLong;
   logic relLongSeen;
   int lat;

   task automatic modelReset();
      mSyncA = 1'b0; mSyncB = 1'b0; mEdges = 0;
      mLevel = 1'b0; mPend = 0; mHeld = 0; mRepeating = 1'b0; mLong = 1'b0;
      mPress = 1'b0; mRelease = 1'b0; mRepeat = 1'b0;
   endtask

   task automatic modelStep();
      mS = mSyncB;
      mSyncB = mSyncA;
      mSyncA = bus.sw;
      mTickNow = ((mEdges % TickPeriod) == 0);
      mEdges++;
      mPress = 1'b0; mRelease = 1'b0; mRepeat = 1'b0;
      if (!mLevel) begin
         if (mPend == 0) begin
            if (mS) mPend = DbTicks;
         end else if (!mS) begin
            mPend = 0;
         end else if (mTickNow) begin
            if (mPend == 1) begin
               mLevel = 1'b1; mPress = 1'b1; mHeld = 0; mRepeating = 1'b0; mPend = 0;
            end else begin
               mPend--;
            end
         end
      end else begin
         if (mPend == 0) begin
            if (!mS) begin
               mPend = DbTicks;
            end else if (mTickNow) begin
               mHeld = (mHeld < 255) ? mHeld + 1 : 255;
               if (mHeld == (mRepeating ? RepeatTicks : HoldTicks)) begin
                  if (!mRepeating) mLong = 1'b1;
                  mRepeat = bus.rpt_en;
                  mRepeating = 1'b1;
                  mHeld = 0;
               end
            end
         end else if (mS) begin
            mPend = 0;
         end else if (mTickNow) begin
            if (mPend == 1) begin
               mLevel = 1'b0; mRelease = 1'b1; mLong = 1'b0; mPend = 0;
            end else begin
               mPend--;
            end
         end
      end
   endtask

   task automatic cmpBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s cycle %0d observed %b expected %b", tag, tbCycle, obs, exp);
      end
   endtask

   task automatic cmpInt(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cmpRange(input string tag, input int obs, input int lo, input int hi);
      bit inRange;
      inRange = (obs >= lo) && (obs <= hi);
      checks++;
      assert (inRange === 1'b1) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic checkOutput();
      cmpBit("db", bus.db, mLevel);
      cmpBit("press_tick", bus.press_tick, mPress);
      cmpBit("release_tick", bus.release_tick, mRelease);
      cmpBit("repeat_tick", bus.repeat_tick, mRepeat);
      cmpBit("long", bus.long, mLong);
      if (bus.press_tick === 1'b1) begin
         pressCnt++;
         lastPressCycle = tbCycle;
      end
      if (bus.release_tick === 1'b1) begin
         releaseCnt++;
         relLongSeen = bus.long;
      end
      if (bus.repeat_tick === 1'b1) repeatCnt++;
      if ((bus.long === 1'b1) && !prevLong) longRiseCycle = tbCycle;
      prevLong = (bus.long === 1'b1);
      tbCycle++;
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic applyStimulus(input logic swVal, input logic rptVal, input int cycles);
      bus.sw = swVal;
      bus.rpt_en = rptVal;
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic waitDb(input logic lvl, input int limit, output int n);
      n = 0;
      while ((bus.db !== lvl) && (n < limit)) begin
         tick();
         n++;
      end
   endtask

   task automatic clearCounts();
      pressCnt = 0; releaseCnt = 0; repeatCnt = 0;
      lastPressCycle = -1000; longRiseCycle = -1; relLongSeen = 1'bx;
   endtask

   // Directed scenarios followed by random switch activity.
   initial begin
      bus.sw = 1'b0;
      bus.rpt_en = 1'b0;
      prevLong = 1'b0;
      clearCounts();
      modelReset();
      #1 reset = 1'b0;
      modelReset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput();
      end
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 20);

      $display("[TB] clean press");
      clearCounts();
      bus.sw = 1'b1;
      waitDb(1'b1, 60, lat);
      cmpRange("press_latency", lat, 19, 35);
      cmpBit("press_with_db", bus.press_tick, 1'b1);
      applyStimulus(1'b1, 1'b1, 60);
      cmpInt("clean_press_count", pressCnt, 1);
      cmpInt("clean_release_count", releaseCnt, 0);
      clearCounts();
      bus.sw = 1'b0;
      waitDb(1'b0, 60, lat);
      cmpRange("release_latency", lat, 19, 35);
      cmpBit("release_with_db", bus.release_tick, 1'b1);
      applyStimulus(1'b0, 1'b1, 40);

      $display("[TB] glitch while released");
      clearCounts();
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b0, 1'b1, 60);
      cmpInt("glitch0_press_count", pressCnt, 0);

      $display("[TB] bouncy press");
      clearCounts();
      for (int i = 0; i < 20; i++) applyStimulus(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 5);
      cmpInt("bounce_early_press", pressCnt, 0);
      applyStimulus(1'b1, 1'b1, 60);
      cmpInt("bounce_press_count", pressCnt, 1);

      $display("[TB] drop glitch while pressed");
      clearCounts();
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b1, 1'b1, 40);
      cmpInt("glitch1_release_count", releaseCnt, 0);
      cmpBit("glitch1_db", bus.db, 1'b1);
      applyStimulus(1'b0, 1'b1, 60);
      cmpBit("after_release_db", bus.db, 1'b0);
      applyStimulus(1'b0, 1'b1, 20);

      $display("[TB] long hold with repeat enabled");
      clearCounts();
      bus.sw = 1'b1;
      waitDb(1'b1, 60, lat);
      applyStimulus(1'b1, 1'b1, 300 - lat);
      cmpInt("long_delay_en", longRiseCycle - lastPressCycle, 64);
      applyStimulus(1'b0, 1'b1, 60);
      cmpRange("repeat_count_en", repeatCnt, 7, 8);
      cmpInt("hold_release_count", releaseCnt, 1);
      cmpBit("release_clears_long", relLongSeen, 1'b0);
      applyStimulus(1'b0, 1'b1, 20);

      $display("[TB] long hold with repeat disabled");
      clearCounts();
      bus.sw = 1'b1;
      bus.rpt_en = 1'b0;
      waitDb(1'b1, 60, lat);
      applyStimulus(1'b1, 1'b0, 300 - lat);
      cmpInt("long_delay_dis", longRiseCycle - lastPressCycle, 64);
      applyStimulus(1'b0, 1'b0, 60);
      cmpInt("repeat_count_dis", repeatCnt, 0);
      applyStimulus(1'b0, 1'b1, 20);

      $display("[TB] reset during repeat phase");
      clearCounts();
      bus.sw = 1'b1;
      waitDb(1'b1, 60, lat);
      applyStimulus(1'b1, 1'b1, 120);
      @(posedge clk);
      modelStep();
      #2 reset = 1'b0;
      modelReset();
      #1;
      cmpBit("rst_db", bus.db, 1'b0);
      cmpBit("rst_long", bus.long, 1'b0);
      cmpBit("rst_press", bus.press_tick, 1'b0);
      cmpBit("rst_release", bus.release_tick, 1'b0);
      cmpBit("rst_repeat", bus.repeat_tick, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput();
      end
      reset = 1'b1;
      clearCounts();
      waitDb(1'b1, 60, lat);
      cmpRange("reset_press_latency", lat, 19, 35);
      applyStimulus(1'b1, 1'b1, 30);
      cmpInt("reset_press_count", pressCnt, 1);
      applyStimulus(1'b0, 1'b1, 60);

      $display("[TB] random activity");
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(1, 70)));
      end
      applyStimulus(1'b0, 1'b1, 60);
      cmpBit("final_db", bus.db, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
